// File: rtl/mask_frame_sender.sv
// OR-downsamples a binary camera mask into a frame buffer and replays it as one raster burst.
// Optional ones counter on the burst is enabled by defining MASK_FRAME_SENDER_COUNT_EN.
module mask_frame_sender #(
  parameter int HORIZONTAL_COUNT = 320,
  parameter int VERTICAL_COUNT   = 180,
  parameter int DS               = 4,
  parameter int CAM_HWIDTH       = 11,
  parameter int CAM_VWIDTH       = 10
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [CAM_HWIDTH-1:0]               cam_hcount_in,
  input  logic [CAM_VWIDTH-1:0]               cam_vcount_in,
  input  logic                                mask_in,
  input  logic                                mask_valid_in,
  input  logic                                skel_busy_in,
  output logic [$clog2(HORIZONTAL_COUNT)-1:0] hcount_out,
  output logic [$clog2(VERTICAL_COUNT)-1:0]   vcount_out,
  output logic                                pixel_out,
  output logic                                pixel_valid_out,
  output logic                                sending_out,
  output logic                                frame_dropped_out
`ifdef MASK_FRAME_SENDER_COUNT_EN
  ,
  output logic [$clog2(HORIZONTAL_COUNT*VERTICAL_COUNT+1)-1:0] ones_count_out,
  output logic                                count_valid_out
`endif
);

  localparam int HW   = $clog2(HORIZONTAL_COUNT);
  localparam int VW   = $clog2(VERTICAL_COUNT);
  localparam int NPIX = HORIZONTAL_COUNT * VERTICAL_COUNT;
  localparam int AW   = $clog2(NPIX);
  localparam int LDS  = $clog2(DS);

  localparam logic [CAM_HWIDTH:0]   H_LIMIT  = (CAM_HWIDTH+1)'(HORIZONTAL_COUNT * DS);
  localparam logic [CAM_VWIDTH:0]   V_LIMIT  = (CAM_VWIDTH+1)'(VERTICAL_COUNT * DS);
  localparam logic [CAM_HWIDTH-1:0] H_SUB    = CAM_HWIDTH'(DS - 1);
  localparam logic [CAM_VWIDTH-1:0] V_SUB    = CAM_VWIDTH'(DS - 1);
  localparam logic [HW-1:0]         X_LAST   = HW'(HORIZONTAL_COUNT - 1);
  localparam logic [VW-1:0]         Y_LAST   = VW'(VERTICAL_COUNT - 1);
  localparam logic [AW-1:0]         A_LAST   = AW'(NPIX - 1);
  localparam logic [AW-1:0]         H_STRIDE = AW'(HORIZONTAL_COUNT);

  typedef enum logic [1:0] {IDLE, CAPTURE, ARM, SEND} state_t;

  state_t                      state_reg, state_next;
  logic [HORIZONTAL_COUNT-1:0] acc_reg, acc_next, acc_base;
  logic [AW-1:0]               rd_addr_reg, rd_addr_next;
  logic [HW-1:0]               rd_x_reg, rd_x_next;
  logic [VW-1:0]               rd_y_reg, rd_y_next;
  logic                        in_window, frame_start, sub_last;
  logic                        capture_en, wr_en, wr_data, drop_next;
  logic [HW-1:0]               x_idx;
  logic [VW-1:0]               y_idx;
  logic [AW-1:0]               wr_addr;
  logic                        mem [0:NPIX-1];
  logic                        rd_data_reg;
  logic                        pixel_valid_reg, drop_reg;
  logic [HW-1:0]               hcount_reg;
  logic [VW-1:0]               vcount_reg;

  assign in_window   = mask_valid_in && ({1'b0, cam_hcount_in} < H_LIMIT)
                                     && ({1'b0, cam_vcount_in} < V_LIMIT);
  assign frame_start = in_window && (cam_hcount_in == '0) && (cam_vcount_in == '0);
  // With DS==1 both masks are zero, so every pixel is the last of its block.
  assign sub_last    = ((cam_hcount_in & H_SUB) == H_SUB) && ((cam_vcount_in & V_SUB) == V_SUB);
  assign x_idx       = cam_hcount_in[LDS +: HW];
  assign y_idx       = cam_vcount_in[LDS +: VW];
  assign wr_addr     = AW'(y_idx) * H_STRIDE + AW'(x_idx);

  always_comb begin
    state_next   = state_reg;
    acc_base     = acc_reg;
    acc_next     = acc_reg;
    capture_en   = 1'b0;
    wr_en        = 1'b0;
    wr_data      = 1'b0;
    drop_next    = 1'b0;
    rd_addr_next = rd_addr_reg;
    rd_x_next    = rd_x_reg;
    rd_y_next    = rd_y_reg;

    case (state_reg)
      IDLE: begin
        if (frame_start) begin
          state_next = CAPTURE;
          capture_en = 1'b1;
          acc_base   = '0;
        end
      end
      CAPTURE: begin
        capture_en = in_window;
        if (frame_start) acc_base = '0;
      end
      ARM: begin
        drop_next = frame_start;
        if (!skel_busy_in) begin
          state_next   = SEND;
          rd_addr_next = '0;
          rd_x_next    = '0;
          rd_y_next    = '0;
        end
      end
      SEND: begin
        drop_next = frame_start;
        if (rd_addr_reg == A_LAST) begin
          state_next   = IDLE;
          rd_addr_next = '0;
          rd_x_next    = '0;
          rd_y_next    = '0;
        end else begin
          rd_addr_next = rd_addr_reg + 1'b1;
          if (rd_x_reg == X_LAST) begin
            rd_x_next = '0;
            rd_y_next = rd_y_reg + 1'b1;
          end else begin
            rd_x_next = rd_x_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    acc_next = acc_base;
    if (capture_en) begin
      wr_data = acc_base[x_idx] | mask_in;
      if (sub_last) begin
        wr_en           = 1'b1;
        acc_next[x_idx] = 1'b0;
        if (x_idx == X_LAST && y_idx == Y_LAST) state_next = ARM;
      end else begin
        acc_next[x_idx] = wr_data;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg       <= IDLE;
      acc_reg         <= '0;
      rd_addr_reg     <= '0;
      rd_x_reg        <= '0;
      rd_y_reg        <= '0;
      pixel_valid_reg <= 1'b0;
      hcount_reg      <= '0;
      vcount_reg      <= '0;
      drop_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      rd_addr_reg     <= rd_addr_next;
      rd_x_reg        <= rd_x_next;
      rd_y_reg        <= rd_y_next;
      pixel_valid_reg <= (state_reg == SEND);
      hcount_reg      <= (state_reg == SEND) ? rd_x_reg : '0;
      vcount_reg      <= (state_reg == SEND) ? rd_y_reg : '0;
      drop_reg        <= drop_next;
    end
  end

  // Frame buffer: no reset so it maps onto block RAM; the read address is always live.
  always_ff @(posedge clk_in) begin
    if (wr_en && !rst_in) mem[wr_addr] <= wr_data;
    rd_data_reg <= mem[rd_addr_reg];
  end

  assign pixel_out         = rd_data_reg & pixel_valid_reg;
  assign pixel_valid_out   = pixel_valid_reg;
  assign sending_out       = (state_reg == SEND) | pixel_valid_reg;
  assign hcount_out        = hcount_reg;
  assign vcount_out        = vcount_reg;
  assign frame_dropped_out = drop_reg;

`ifdef MASK_FRAME_SENDER_COUNT_EN
  localparam int CW = $clog2(NPIX + 1);

  logic [CW-1:0] run_count_reg, ones_count_reg;
  logic          last_beat_reg, count_valid_reg;

  // last_beat_reg lines up with the final valid beat, so the total latches the cycle after.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      run_count_reg   <= '0;
      ones_count_reg  <= '0;
      last_beat_reg   <= 1'b0;
      count_valid_reg <= 1'b0;
    end else begin
      last_beat_reg   <= (state_reg == SEND) && (rd_addr_reg == A_LAST);
      count_valid_reg <= last_beat_reg;
      if (state_reg == ARM && state_next == SEND) run_count_reg <= '0;
      else if (pixel_out)                         run_count_reg <= run_count_reg + 1'b1;
      if (last_beat_reg) ones_count_reg <= run_count_reg + CW'(pixel_out);
    end
  end

  assign ones_count_out  = ones_count_reg;
  assign count_valid_out = count_valid_reg;
`endif

endmodule

// File: tb/tb_mask_frame_sender.sv
// Directed bench for mask_frame_sender on an 8x4 output frame (32x16 camera window, DS=4).
// Exercises MASK_FRAME_SENDER_COUNT_EN outputs when that macro is defined.
module tb_mask_frame_sender;

  localparam int H        = 8;
  localparam int V        = 4;
  localparam int DSF      = 4;
  localparam int N        = H * V;
  localparam int CAM_COLS = 40;
  localparam int LAST_CX  = H * DSF - 1;
  localparam int LAST_CY  = V * DSF - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] cam_h = '0;
  logic [9:0]  cam_v = '0;
  logic        mask = 1'b0;
  logic        mask_valid = 1'b0;
  logic        busy = 1'b0;
  logic [2:0]  hcount;
  logic [1:0]  vcount;
  logic        pixel, pixel_valid, sending, dropped;
`ifdef MASK_FRAME_SENDER_COUNT_EN
  logic [5:0]  ones_count;
  logic        count_valid;
`endif

  mask_frame_sender #(
    .HORIZONTAL_COUNT(H), .VERTICAL_COUNT(V), .DS(DSF), .CAM_HWIDTH(11), .CAM_VWIDTH(10)
  ) dut (
    .clk_in(clk), .rst_in(rst),
    .cam_hcount_in(cam_h), .cam_vcount_in(cam_v),
    .mask_in(mask), .mask_valid_in(mask_valid), .skel_busy_in(busy),
    .hcount_out(hcount), .vcount_out(vcount), .pixel_out(pixel),
    .pixel_valid_out(pixel_valid), .sending_out(sending), .frame_dropped_out(dropped)
`ifdef MASK_FRAME_SENDER_COUNT_EN
    , .ones_count_out(ones_count), .count_valid_out(count_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int cx; int cy; bit chk; int ox; int oy;
  } vec_t;

  vec_t vecs [0:8];
  bit   exp_img [0:N-1];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected image: checkerboard, a single set output pixel, or all zero (ox < 0).
  task automatic build_exp(input bit is_chk, input int ox, input int oy);
    for (int k = 0; k < N; k++)
      exp_img[k] = is_chk ? bit'(((k % H) + (k / H)) % 2) : (k == oy * H + ox);
  endtask

  // Drives the camera raster up to (stop_x, stop_y) inclusive, then releases valid.
  task automatic drive_frame(input int cx, input int cy, input bit is_chk,
                             input int stop_x, input int stop_y);
    for (int i = 0; i <= stop_y * CAM_COLS + stop_x; i++) begin
      int x, y;
      x = i % CAM_COLS;
      y = i / CAM_COLS;
      cam_h      = 11'(x);
      cam_v      = 10'(y);
      mask_valid = 1'b1;
      mask       = is_chk ? 1'(((x / DSF) + (y / DSF)) % 2) : (x == cx && y == cy);
      tick();
    end
    mask_valid = 1'b0;
    mask       = 1'b0;
  endtask

  // Waits for the burst, checks every beat against exp_img, optionally injects a frame start.
  task automatic recv_burst(input string tag, input int exp_lat, input int inject,
                            input int exp_drops);
    int wait_c = 0;
    int drops  = 0;
    int ones   = 0;
    while (!pixel_valid && wait_c < 20) begin
      tick();
      wait_c++;
    end
    chk({tag, "_start_latency"}, wait_c, exp_lat);
    if (!pixel_valid) return;
    for (int k = 0; k < N; k++) begin
      chk({tag, "_valid"}, int'(pixel_valid), 1);
      chk({tag, "_sending"}, int'(sending), 1);
      chk({tag, "_hcount"}, int'(hcount), k % H);
      chk({tag, "_vcount"}, int'(vcount), k / H);
      chk({tag, "_pixel"}, int'(pixel), int'(exp_img[k]));
      if (exp_img[k]) ones++;
      if (dropped) drops++;
      if (k == inject) begin
        cam_h = '0; cam_v = '0; mask = 1'b1; mask_valid = 1'b1;
      end else begin
        mask = 1'b0; mask_valid = 1'b0;
      end
      tick();
    end
    mask_valid = 1'b0;
    mask       = 1'b0;
    chk({tag, "_end_valid"}, int'(pixel_valid), 0);
    chk({tag, "_end_sending"}, int'(sending), 0);
`ifdef MASK_FRAME_SENDER_COUNT_EN
    chk({tag, "_count_valid"}, int'(count_valid), 1);
    chk({tag, "_ones_count"}, int'(ones_count), ones);
`endif
    for (int i = 0; i < 3; i++) begin
      if (dropped) drops++;
      tick();
`ifdef MASK_FRAME_SENDER_COUNT_EN
      chk({tag, "_count_valid_pulse"}, int'(count_valid), 0);
`endif
    end
    chk({tag, "_drop_pulses"}, drops, exp_drops);
    chk({tag, "_idle_valid"}, int'(pixel_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{cx: -1, cy: -1, chk: 1'b0, ox: -1, oy: -1};
    vecs[1] = '{cx:  5, cy:  6, chk: 1'b0, ox:  1, oy:  1};
    vecs[2] = '{cx: 31, cy: 15, chk: 1'b0, ox:  7, oy:  3};
    vecs[3] = '{cx:  0, cy:  0, chk: 1'b0, ox:  0, oy:  0};
    vecs[4] = '{cx:  3, cy:  3, chk: 1'b0, ox:  0, oy:  0};
    vecs[5] = '{cx: 29, cy:  2, chk: 1'b0, ox:  7, oy:  0};
    vecs[6] = '{cx: 33, cy:  5, chk: 1'b0, ox: -1, oy: -1};
    vecs[7] = '{cx: 17, cy: 14, chk: 1'b0, ox:  4, oy:  3};
    vecs[8] = '{cx: -1, cy: -1, chk: 1'b1, ox: -1, oy: -1};

    repeat (3) tick();
    chk("rst_valid", int'(pixel_valid), 0);
    chk("rst_sending", int'(sending), 0);
    rst = 1'b0;
    tick();
    chk("reset_hcount", int'(hcount), 0);
    chk("reset_vcount", int'(vcount), 0);
    chk("reset_pixel", int'(pixel), 0);
    chk("reset_valid", int'(pixel_valid), 0);
    chk("reset_sending", int'(sending), 0);
    chk("reset_dropped", int'(dropped), 0);
`ifdef MASK_FRAME_SENDER_COUNT_EN
    chk("reset_ones_count", int'(ones_count), 0);
    chk("reset_count_valid", int'(count_valid), 0);
`endif

    for (int i = 0; i < 9; i++) begin
      $display("vector %0d: cam(%0d,%0d) chk=%0d -> out(%0d,%0d)",
               i, vecs[i].cx, vecs[i].cy, vecs[i].chk, vecs[i].ox, vecs[i].oy);
      build_exp(vecs[i].chk, vecs[i].ox, vecs[i].oy);
      drive_frame(vecs[i].cx, vecs[i].cy, vecs[i].chk, LAST_CX, LAST_CY);
      recv_burst("vec", 2, -1, 0);
    end

    // Busy held after capture: the frame waits in ARM, then sends once busy drops.
    $display("sequence: busy hold");
    busy = 1'b1;
    build_exp(1'b0, 7, 3);
    drive_frame(31, 15, 1'b0, LAST_CX, LAST_CY);
    begin
      int seen = 0;
      for (int i = 0; i < 100; i++) begin
        if (pixel_valid || sending) seen++;
        tick();
      end
      chk("busy_hold_quiet", seen, 0);
    end
    busy = 1'b0;
    tick();
    chk("busy_release_sending", int'(sending), 1);
    chk("busy_release_valid", int'(pixel_valid), 0);
    tick();
    chk("busy_release_valid2", int'(pixel_valid), 1);
    recv_burst("busy", 0, -1, 0);

    // Frame start during SEND is dropped with one pulse; the next frame captures normally.
    $display("sequence: drop during send");
    build_exp(1'b0, 1, 1);
    drive_frame(5, 6, 1'b0, LAST_CX, LAST_CY);
    recv_burst("drop", 2, 5, 1);
    build_exp(1'b0, 4, 3);
    drive_frame(17, 14, 1'b0, LAST_CX, LAST_CY);
    recv_burst("after_drop", 2, -1, 0);

    // Truncated frame leaves acc[1] set; the restart must clear it.
    $display("sequence: truncated frame restart");
    drive_frame(5, 6, 1'b0, 20, 6);
    build_exp(1'b0, 4, 3);
    drive_frame(17, 14, 1'b0, LAST_CX, LAST_CY);
    recv_burst("restart", 2, -1, 0);

    // Reset mid-burst abandons the frame; a new one then goes through in full.
    $display("sequence: reset mid-send");
    build_exp(1'b0, 0, 0);
    drive_frame(0, 0, 1'b0, LAST_CX, LAST_CY);
    begin
      int wait_c = 0;
      while (!pixel_valid && wait_c < 20) begin
        tick();
        wait_c++;
      end
      chk("rst_burst_start", int'(pixel_valid), 1);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_valid", int'(pixel_valid), 0);
      chk("rst_mid_sending", int'(sending), 0);
      chk("rst_mid_hcount", int'(hcount), 0);
      rst = 1'b0;
      wait_c = 0;
      for (int i = 0; i < 10; i++) begin
        if (pixel_valid || sending) wait_c++;
        tick();
      end
      chk("rst_stays_idle", wait_c, 0);
    end
    build_exp(1'b1, -1, -1);
    drive_frame(-1, -1, 1'b1, LAST_CX, LAST_CY);
    recv_burst("post_rst", 2, -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
